// File: rtl/vedic_16x16_seq.sv
// vedic_16x16_seq: 16x16 unsigned multiplier time-multiplexing one vedic_8x8 over four cycles

// 2x2 vedic cell: vertical and crosswise products of single bits
module vedic_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic x0, x1, hh, c;
    assign x0     = a_i[1] & b_i[0];
    assign x1     = a_i[0] & b_i[1];
    assign hh     = a_i[1] & b_i[1];
    assign c      = x0 & x1;
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = x0 ^ x1;
    assign p_o[2] = hh ^ c;
    assign p_o[3] = hh & c;
endmodule

// 4x4 vedic multiplier built from four 2x2 cells
module vedic_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    vedic_2x2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0));
    vedic_2x2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1));
    vedic_2x2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2));
    vedic_2x2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3));
    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p_o = {4'b0, q0} + {1'b0, mid, 2'b0} + {q3, 4'b0};
endmodule

// 8x8 vedic multiplier built from four 4x4 blocks
module vedic_8x8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;
    vedic_4x4 u_ll (.a_i(a_i[3:0]), .b_i(b_i[3:0]), .p_o(q0));
    vedic_4x4 u_hl (.a_i(a_i[7:4]), .b_i(b_i[3:0]), .p_o(q1));
    vedic_4x4 u_lh (.a_i(a_i[3:0]), .b_i(b_i[7:4]), .p_o(q2));
    vedic_4x4 u_hh (.a_i(a_i[7:4]), .b_i(b_i[7:4]), .p_o(q3));
    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p_o = {8'b0, q0} + {3'b0, mid, 4'b0} + {q3, 8'b0};
endmodule

// Sequential 16x16 top: one partial product per MUL cycle into a 32-bit accumulator
module vedic_16x16_seq #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, b_q;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  step_q;
    logic [7:0]  op_a, op_b;
    logic [15:0] pp;
    logic [31:0] pp_sh;
    logic        accept, zero_hit;

    // step bit 0 selects the high byte of a, bit 1 the high byte of b
    assign op_a = step_q[0] ? a_q[15:8] : a_q[7:0];
    assign op_b = step_q[1] ? b_q[15:8] : b_q[7:0];

    vedic_8x8 u_mul (.a_i(op_a), .b_i(op_b), .p_o(pp));

    assign accept   = in_valid && in_ready;
    assign zero_hit = EARLY_ZERO && (step_q == 2'd0) && (a_q == 16'd0 || b_q == 16'd0);
    assign pp_sh    = (step_q == 2'd3) ? {pp, 16'b0} : (step_q == 2'd0) ? {16'b0, pp} : {8'b0, pp, 8'b0};
    assign acc_d    = zero_hit ? 32'd0 : acc_q + pp_sh;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state: accept starts MUL, step 3 or an early zero finishes, consume returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? MUL : IDLE;
            MUL:     state_d = (zero_hit || step_q == 2'd3) ? DONE : MUL;
            DONE:    state_d = accept ? MUL : (out_ready ? IDLE : DONE);
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from registered state; in_ready also looks at out_ready for back-to-back
    always_comb begin
        in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
        out_valid = (state_q == DONE);
        busy      = (state_q == MUL);
        result    = acc_q;
    end

    // operand latch, accumulator and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            step_q <= '0;
        end else if (state_q == MUL) begin
            acc_q  <= acc_d;
            step_q <= step_q + 2'd1;
        end
    end
endmodule
